// File: rtl/commit_controller.sv
// Commit controller: retires the ROB head in order. Register writes, store
// handshake with the LSB, branch mispredict flush and halt. All outputs are registered.
module commit_controller #(
  parameter int XLEN           = 32,
  parameter int REG_CNT_WIDTH  = 5,
  parameter int ROB_SIZE_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  // ROB head
  input  logic                      rob_head_valid,
  input  logic                      rob_head_ready,
  input  logic [1:0]                rob_head_kind,
  input  logic [REG_CNT_WIDTH-1:0]  rob_head_rd,
  input  logic [XLEN-1:0]           rob_head_val,
  input  logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
  input  logic                      rob_head_mispredict,
  input  logic [XLEN-1:0]           rob_head_target,
  // retire / register file
  output logic                      commit_pop,
  output logic                      rf_wr_en,
  output logic [REG_CNT_WIDTH-1:0]  rf_wr_rd,
  output logic [XLEN-1:0]           rf_wr_val,
  output logic [ROB_SIZE_WIDTH-1:0] rf_wr_rob_id,
  // store handshake, flush, halt, stats
  output logic                      store_req,
  input  logic                      lsb_store_done,
  output logic                      flush,
  output logic [XLEN-1:0]           flush_pc,
  output logic                      halt,
  output logic [31:0]               commit_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_STORE, S_FLUSH, S_HALT} state_t;

  localparam logic [1:0] K_ALU  = 2'd0;
  localparam logic [1:0] K_BR   = 2'd1;
  localparam logic [1:0] K_ST   = 2'd2;
  localparam logic [1:0] K_HALT = 2'd3;

  state_t                    r_state;
  logic                      r_commit_pop;
  logic                      r_rf_wr_en;
  logic [REG_CNT_WIDTH-1:0]  r_rf_wr_rd;
  logic [XLEN-1:0]           r_rf_wr_val;
  logic [ROB_SIZE_WIDTH-1:0] r_rf_wr_rob_id;
  logic                      r_store_req;
  logic                      r_flush;
  logic [XLEN-1:0]           r_flush_pc;
  logic                      r_halt;
  logic [31:0]               r_commit_cnt;

  // Head is eligible only while the previous pop is not still on the wire,
  // so the ROB gets one cycle to advance its head pointer.
  logic w_can_commit;
  assign w_can_commit = rob_head_valid && rob_head_ready && !r_commit_pop;

  // Commit FSM: pulses default low each cycle; rf_wr_* payload holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_commit_pop   <= 1'b0;
      r_rf_wr_en     <= 1'b0;
      r_rf_wr_rd     <= '0;
      r_rf_wr_val    <= '0;
      r_rf_wr_rob_id <= '0;
      r_store_req    <= 1'b0;
      r_flush        <= 1'b0;
      r_flush_pc     <= '0;
      r_halt         <= 1'b0;
      r_commit_cnt   <= '0;
    end else begin
      r_commit_pop <= 1'b0;
      r_rf_wr_en   <= 1'b0;
      r_flush      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_can_commit) begin
            case (rob_head_kind)
              K_ALU, K_BR: begin
                r_commit_pop <= 1'b1;
                r_commit_cnt <= r_commit_cnt + 32'd1;
                // x0 is hardwired; retire without touching the register file
                if (rob_head_rd != '0) begin
                  r_rf_wr_en     <= 1'b1;
                  r_rf_wr_rd     <= rob_head_rd;
                  r_rf_wr_val    <= rob_head_val;
                  r_rf_wr_rob_id <= rob_head_id;
                end
                if (rob_head_kind == K_BR && rob_head_mispredict) begin
                  r_flush    <= 1'b1;
                  r_flush_pc <= rob_head_target;
                  r_state    <= S_FLUSH;
                end
              end
              K_ST: begin
                r_store_req <= 1'b1;
                r_state     <= S_STORE;
              end
              default: begin  // K_HALT
                r_commit_pop <= 1'b1;
                r_commit_cnt <= r_commit_cnt + 32'd1;
                r_halt       <= 1'b1;
                r_state      <= S_HALT;
              end
            endcase
          end
        end
        S_STORE: begin
          // Pop only once the LSB confirms the store reached memory
          if (lsb_store_done) begin
            r_store_req  <= 1'b0;
            r_commit_pop <= 1'b1;
            r_commit_cnt <= r_commit_cnt + 32'd1;
            r_state      <= S_IDLE;
          end
        end
        S_FLUSH: begin
          // Head contents are stale during the flush; skip one cycle
          r_state <= S_IDLE;
        end
        default: begin  // S_HALT: only reset leaves
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign commit_pop   = r_commit_pop;
  assign rf_wr_en     = r_rf_wr_en;
  assign rf_wr_rd     = r_rf_wr_rd;
  assign rf_wr_val    = r_rf_wr_val;
  assign rf_wr_rob_id = r_rf_wr_rob_id;
  assign store_req    = r_store_req;
  assign flush        = r_flush;
  assign flush_pc     = r_flush_pc;
  assign halt         = r_halt;
  assign commit_cnt   = r_commit_cnt;

endmodule

// File: tb/tb_commit_controller.sv
// Bench for commit_controller: stimulus pushes expected retire records into a
// queue; a negedge monitor pops and compares on every commit_pop.
module tb_commit_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rob_head_valid = 1'b0;
  logic        rob_head_ready = 1'b0;
  logic [1:0]  rob_head_kind = 2'd0;
  logic [4:0]  rob_head_rd = '0;
  logic [31:0] rob_head_val = '0;
  logic [2:0]  rob_head_id = '0;
  logic        rob_head_mispredict = 1'b0;
  logic [31:0] rob_head_target = '0;
  logic        lsb_store_done = 1'b0;
  logic        commit_pop, rf_wr_en, store_req, flush, halt;
  logic [4:0]  rf_wr_rd;
  logic [31:0] rf_wr_val, flush_pc, commit_cnt;
  logic [2:0]  rf_wr_rob_id;

  commit_controller dut (
    .clk(clk), .rst(rst),
    .rob_head_valid(rob_head_valid), .rob_head_ready(rob_head_ready),
    .rob_head_kind(rob_head_kind), .rob_head_rd(rob_head_rd),
    .rob_head_val(rob_head_val), .rob_head_id(rob_head_id),
    .rob_head_mispredict(rob_head_mispredict), .rob_head_target(rob_head_target),
    .commit_pop(commit_pop), .rf_wr_en(rf_wr_en), .rf_wr_rd(rf_wr_rd),
    .rf_wr_val(rf_wr_val), .rf_wr_rob_id(rf_wr_rob_id),
    .store_req(store_req), .lsb_store_done(lsb_store_done),
    .flush(flush), .flush_pc(flush_pc), .halt(halt), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [2:0]  id;
    logic        fl;
    logic [31:0] fpc;
    logic        hlt;
    logic        st;
    logic [31:0] cnt;
  } rec_t;

  rec_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_cnt = '0;
  logic [4:0]  h_rd = '0;
  logic [31:0] h_val = '0;
  logic [2:0]  h_id = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // All outputs concatenated; zero after reset
  function automatic logic [127:0] all_outs();
    return {19'd0, commit_pop, rf_wr_en, rf_wr_rd, rf_wr_val, rf_wr_rob_id,
            store_req, flush, flush_pc, halt, commit_cnt};
  endfunction

  task automatic head(input logic v, input logic [1:0] k, input logic [4:0] rd,
                      input logic [31:0] val, input logic [2:0] id,
                      input logic mp, input logic [31:0] tgt);
    rob_head_valid = v; rob_head_ready = v; rob_head_kind = k;
    rob_head_rd = rd; rob_head_val = val; rob_head_id = id;
    rob_head_mispredict = mp; rob_head_target = tgt;
  endtask

  // Expected record for the next pop; rf payload holds previous write when wr=0
  task automatic push(input logic wr, input logic [4:0] rd, input logic [31:0] val,
                      input logic [2:0] id, input logic fl, input logic [31:0] fpc,
                      input logic hlt);
    rec_t r;
    exp_cnt = exp_cnt + 32'd1;
    if (wr) begin h_rd = rd; h_val = val; h_id = id; end
    r = '{wr: wr, rd: h_rd, val: h_val, id: h_id, fl: fl,
          fpc: (fl ? fpc : 32'd0), hlt: hlt, st: 1'b0, cnt: exp_cnt};
    exp_q.push_back(r);
  endtask

  // Monitor: every retire must match the oldest expected record
  always @(negedge clk) begin
    rec_t a, e;
    if (!rst && commit_pop) begin
      a = '{wr: rf_wr_en, rd: rf_wr_rd, val: rf_wr_val, id: rf_wr_rob_id, fl: flush,
            fpc: (flush ? flush_pc : 32'd0), hlt: halt, st: store_req, cnt: commit_cnt};
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected actual=%0h required=no_pop", a);
      end else begin
        e = exp_q.pop_front();
        if (a === e) n_pass++;
        else $display("FAIL pop_cnt%0d actual=%0h required=%0h", e.cnt, a, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    check("reset_state", all_outs(), 128'd0);
    @(negedge clk); rst = 1'b0;

    // kind 0 held: pops every other cycle
    head(1, 2'd0, 5'd5, 32'h1234, 3'd2, 0, 0);
    push(1, 5'd5, 32'h1234, 3'd2, 0, 0, 0);
    push(1, 5'd5, 32'h1234, 3'd2, 0, 0, 0);
    push(1, 5'd5, 32'h1234, 3'd2, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("alu_gap_hold", {commit_pop, rf_wr_en, rf_wr_rd, rf_wr_val, rf_wr_rob_id},
          {1'b0, 1'b0, 5'd5, 32'h1234, 3'd2});
    repeat (4) @(negedge clk);
    head(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // kind 0, rd=0: pop without write
    head(1, 2'd0, 5'd0, 32'h55, 3'd3, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); head(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // lsb_store_done outside STORE is ignored
    lsb_store_done = 1'b1;
    repeat (2) @(negedge clk);
    check("done_idle_ignored", {commit_pop, store_req, commit_cnt}, {1'b0, 1'b0, exp_cnt});
    lsb_store_done = 1'b0;

    // kind 2: store_req until done, then single pop
    head(1, 2'd2, 5'd7, 32'h5, 3'd4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("store_wait%0d", i), {rf_wr_en, commit_pop, store_req}, 3'b001);
    end
    lsb_store_done = 1'b1;
    push(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    lsb_store_done = 1'b0; head(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("store_after", {commit_pop, store_req, rf_wr_en}, 3'b000);

    // kind 1 mispredict: one-cycle flush, write rd=1
    head(1, 2'd1, 5'd1, 32'hAB, 3'd5, 1, 32'h100);
    push(1, 5'd1, 32'hAB, 3'd5, 1, 32'h100, 0);
    @(negedge clk);
    @(negedge clk);
    check("flush_one_cycle", {flush, commit_pop, rf_wr_en}, 3'b000);
    head(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // kind 1 correctly predicted: write, no flush
    head(1, 2'd1, 5'd3, 32'h77, 3'd6, 0, 32'h200);
    push(1, 5'd3, 32'h77, 3'd6, 0, 0, 0);
    @(negedge clk); head(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset mid-STORE: everything clears asynchronously
    head(1, 2'd2, 5'd7, 32'h6, 3'd4, 0, 0);
    @(negedge clk);
    check("store_before_rst", {1'b0, store_req}, 2'b01);
    head(0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 check("rst_mid_store", all_outs(), 128'd0);
    @(negedge clk); rst = 1'b0;
    exp_cnt = '0; h_rd = '0; h_val = '0; h_id = '0;
    head(1, 2'd0, 5'd9, 32'h99, 3'd1, 0, 0);
    push(1, 5'd9, 32'h99, 3'd1, 0, 0, 0);
    @(negedge clk); head(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Counter wrap from 0xFFFFFFFF
    force dut.r_commit_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_commit_cnt;
    exp_cnt = 32'hFFFF_FFFF;
    head(1, 2'd0, 5'd2, 32'h22, 3'd7, 0, 0);
    push(1, 5'd2, 32'h22, 3'd7, 0, 0, 0);
    @(negedge clk); head(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // kind 3: one pop, halt sticky, later heads ignored
    head(1, 2'd3, 5'd0, 32'h0, 3'd0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    head(1, 2'd0, 5'd4, 32'h44, 3'd3, 0, 0);
    repeat (4) @(negedge clk);
    check("halt_sticky", {halt, rf_wr_en, commit_cnt}, {1'b1, 1'b0, exp_cnt});
    #2 rst = 1'b1;
    #1 check("rst_in_halt", all_outs(), 128'd0);
    head(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/commit_controller.md
COMMIT_CONTROLLER -- requirements
Module: commit_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter REG_CNT_WIDTH, default 5, architectural register index width.
REQ-003 SHALL have parameter ROB_SIZE_WIDTH, default 3, ROB entry id width.
REQ-004 SHALL have ports: clk input 1, sole clock, rising edge; rst input 1, reset, asynchronous, active-high.
REQ-005 SHALL have ROB head ports: rob_head_valid input 1, head entry exists; rob_head_ready input 1, head result computed; rob_head_kind input 2, 0=ALU/load, 1=branch/jump, 2=store, 3=halt; rob_head_rd input REG_CNT_WIDTH, destination; rob_head_val input XLEN, result; rob_head_id input ROB_SIZE_WIDTH, head entry id; rob_head_mispredict input 1, branch mispredicted; rob_head_target input XLEN, correct PC.
REQ-006 SHALL have ports: commit_pop output 1, retire head; rf_wr_en output 1, register file write; rf_wr_rd output REG_CNT_WIDTH; rf_wr_val output XLEN; rf_wr_rob_id output ROB_SIZE_WIDTH, id used for dependency clear.
REQ-007 SHALL have ports: store_req output 1, permit LSB to perform head store; lsb_store_done input 1, store finished; flush output 1, pipeline flush; flush_pc output XLEN, redirect PC; halt output 1, sticky stop; commit_cnt output 32, retired instruction count.

Function
REQ-008 SHALL implement FSM states IDLE, STORE, FLUSH, HALT; all outputs registered.
REQ-009 SHALL, in IDLE, commit only when rob_head_valid=1, rob_head_ready=1 and commit_pop=0 in the current cycle (max one commit per two cycles; prevents double pop before ROB head advances).
REQ-010 SHALL, for kind 0 commit: next cycle commit_pop=1 for one cycle; rf_wr_en=1 for one cycle with rd/val/id copied from head iff rob_head_rd!=0; stay IDLE.
REQ-011 SHALL, for kind 1 commit: perform REQ-010 write/pop; if rob_head_mispredict=1 also assert flush=1 and flush_pc=rob_head_target for exactly one cycle and go to FLUSH.
REQ-012 SHALL, in FLUSH, ignore all head inputs for one cycle, then return to IDLE; flush deasserts after that one cycle.
REQ-013 SHALL, for kind 2 commit: assert store_req next cycle, enter STORE, no pop, no register write.
REQ-014 SHALL, in STORE, hold store_req=1 until lsb_store_done=1 is sampled; then next cycle store_req=0, commit_pop=1 one cycle, return to IDLE; head inputs ignored in STORE.
REQ-015 SHALL, for kind 3 commit: pop once, set halt=1 permanently, enter HALT; HALT is left only by rst.
REQ-016 SHALL ignore lsb_store_done outside STORE.
REQ-017 SHALL increment commit_cnt by 1 in the same cycle commit_pop is 1, modulo 2^32 (0xFFFFFFFF wraps to 0).
REQ-018 SHALL hold rf_wr_rd/rf_wr_val/rf_wr_rob_id stable when rf_wr_en=0 (last written values).
REQ-019 SHALL never assert rf_wr_en and store_req in the same cycle, nor commit_pop while flush=1 except the single branch commit cycle of REQ-011.

Reset
REQ-020 SHALL on rst=1, immediately and regardless of clk: state=IDLE, commit_pop=0, rf_wr_en=0, rf_wr_rd=0, rf_wr_val=0, rf_wr_rob_id=0, store_req=0, flush=0, flush_pc=0, halt=0, commit_cnt=0.
REQ-021 SHALL, on rst mid-STORE or in HALT, drop store_req/halt asynchronously and resume commits from the first rising edge after rst deasserts.

Verification
REQ-022 Bench SHALL cover: kind 0, rd=5, val=0x1234, id=2, valid/ready held -> rf_wr_en pulses rd=5 val=0x1234 id=2 with commit_pop, repeats every 2 cycles, commit_cnt increments each pop.
REQ-023 Bench SHALL cover: kind 0 with rd=0 -> commit_pop=1, rf_wr_en=0, commit_cnt+1.
REQ-024 Bench SHALL cover: kind 2, lsb_store_done after 4 cycles -> store_req high exactly until done sampled, single commit_pop next cycle, no rf write.
REQ-025 Bench SHALL cover: kind 1, mispredict=1, target=0x100, rd=1 -> one cycle flush=1, flush_pc=0x100, rf write rd=1, head ignored next cycle.
REQ-026 Bench SHALL cover: kind 3 -> one pop, halt stays 1, further valid heads ignored; rst asserted mid-STORE and with commit_cnt preloaded to 0xFFFFFFFF -> wrap to 0 on next pop, all outputs 0 asynchronously on rst.
